// File: rtl/regfile_rename_mw_pkg.sv
// regfile_rename_mw_pkg: shared ROB tag width, ENTRY_NULL, NULL-register encoding (bit5), TRUE/FALSE and live-register helper
package regfile_rename_mw_pkg;
  localparam int ROB_W = 4;
  localparam logic [ROB_W-1:0] ENTRY_NULL = '1;
  localparam int REG_NULL_BIT = 5;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  function automatic logic rd_live(input logic [5:0] r);
    return !r[REG_NULL_BIT] && r[4:0] != '0;
  endfunction
endpackage

// File: rtl/regfile_rename_rdport.sv
// regfile_rename_rdport: one operand read (NULL/x0, in-group forward, busy tag, optional commit bypass under REGFILE_CMT_BYPASS_EN, value); in src/older/iss_rd/iss_tag/busy/tag/value[/byp_en/cmt_*], out q/v
module regfile_rename_rdport
  import regfile_rename_mw_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ISSUE_W = 2
`ifdef REGFILE_CMT_BYPASS_EN
  ,
  parameter int COMMIT_W = 2
`endif
) (
  input  logic [5:0]               src,
  input  logic [ISSUE_W-1:0]       older,
  input  logic [6*ISSUE_W-1:0]     iss_rd,
  input  logic [ROB_W*ISSUE_W-1:0] iss_tag,
  input  logic                     busy,
  input  logic [ROB_W-1:0]         tag,
  input  logic [XLEN-1:0]          value,
`ifdef REGFILE_CMT_BYPASS_EN
  input  logic                      byp_en,
  input  logic [COMMIT_W-1:0]       cmt_valid,
  input  logic [ROB_W*COMMIT_W-1:0] cmt_tag,
  input  logic [6*COMMIT_W-1:0]     cmt_rd,
  input  logic [XLEN*COMMIT_W-1:0]  cmt_data,
`endif
  output logic [ROB_W-1:0]         q,
  output logic [XLEN-1:0]          v
);
  logic zero, fwd, byp;
  logic [ROB_W-1:0] fwd_tag;
  logic [XLEN-1:0] byp_data;
  always_comb begin
    fwd = FALSE;
    fwd_tag = ENTRY_NULL;
    for (int j = 0; j < ISSUE_W; j++)
      if (older[j] && iss_rd[6*j+:6] == src) begin
        fwd = TRUE;
        fwd_tag = iss_tag[ROB_W*j+:ROB_W];
      end
  end
`ifdef REGFILE_CMT_BYPASS_EN
  always_comb begin
    byp = FALSE;
    byp_data = '0;
    for (int c = 0; c < COMMIT_W; c++)
      if (byp_en && cmt_valid[c] && cmt_rd[6*c+:6] == src && cmt_tag[ROB_W*c+:ROB_W] == tag) begin
        byp = TRUE;
        byp_data = cmt_data[XLEN*c+:XLEN];
      end
  end
`else
  assign byp = FALSE;
  assign byp_data = '0;
`endif
  assign zero = !rd_live(src);
  assign q = zero ? ENTRY_NULL : fwd ? fwd_tag : (busy && !byp) ? tag : ENTRY_NULL;
  assign v = (zero || fwd) ? '0 : !busy ? value : byp ? byp_data : '0;
endmodule

// File: rtl/regfile_rename_mw.sv
// regfile_rename_mw: multi-issue/multi-commit register file with busy/ROB-tag rename table (optional REGFILE_CMT_BYPASS_EN); in clk/rst/rdy/rollback/iss_*/cmt_*, out Qj/Qk/Vj/Vk per issue lane
module regfile_rename_mw
  import regfile_rename_mw_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int ISSUE_W = 2,
  parameter int COMMIT_W = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      rollback,
  input  logic [ISSUE_W-1:0]        iss_valid,
  input  logic [6*ISSUE_W-1:0]      iss_rd,
  input  logic [6*ISSUE_W-1:0]      iss_rs1,
  input  logic [6*ISSUE_W-1:0]      iss_rs2,
  input  logic [ROB_W*ISSUE_W-1:0]  iss_tag,
  output logic [ROB_W*ISSUE_W-1:0]  Qj,
  output logic [ROB_W*ISSUE_W-1:0]  Qk,
  output logic [XLEN*ISSUE_W-1:0]   Vj,
  output logic [XLEN*ISSUE_W-1:0]   Vk,
  input  logic [COMMIT_W-1:0]       cmt_valid,
  input  logic [ROB_W*COMMIT_W-1:0] cmt_tag,
  input  logic [6*COMMIT_W-1:0]     cmt_rd,
  input  logic [XLEN*COMMIT_W-1:0]  cmt_data
);
  logic [XLEN-1:0] value_q [NREG];
  logic [XLEN-1:0] value_d [NREG];
  logic [ROB_W-1:0] reorder_q [NREG];
  logic [ROB_W-1:0] reorder_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  always_comb begin
    value_d = value_q;
    busy_d = busy_q;
    reorder_d = reorder_q;
    for (int c = 0; c < COMMIT_W; c++)
      if ((rollback || rdy) && cmt_valid[c] && rd_live(cmt_rd[6*c+:6]))
        value_d[cmt_rd[6*c+:5]] = cmt_data[XLEN*c+:XLEN];
    if (rollback) begin
      busy_d = '0;
      reorder_d = '{default: ENTRY_NULL};
    end else if (rdy) begin
      for (int c = 0; c < COMMIT_W; c++)
        if (cmt_valid[c] && rd_live(cmt_rd[6*c+:6]) && reorder_q[cmt_rd[6*c+:5]] == cmt_tag[ROB_W*c+:ROB_W]) begin
          busy_d[cmt_rd[6*c+:5]] = FALSE;
          reorder_d[cmt_rd[6*c+:5]] = ENTRY_NULL;
        end
      for (int k = 0; k < ISSUE_W; k++)
        if (iss_valid[k] && rd_live(iss_rd[6*k+:6])) begin
          busy_d[iss_rd[6*k+:5]] = TRUE;
          reorder_d[iss_rd[6*k+:5]] = iss_tag[ROB_W*k+:ROB_W];
        end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      value_q <= '{default: '0};
      busy_q <= '0;
      reorder_q <= '{default: ENTRY_NULL};
    end else begin
      value_q <= value_d;
      busy_q <= busy_d;
      reorder_q <= reorder_d;
    end
  for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
    localparam logic [ISSUE_W-1:0] OLDER = ISSUE_W'((1 << k) - 1);
    logic [4:0] a, b;
    assign a = iss_rs1[6*k+:5];
    assign b = iss_rs2[6*k+:5];
    regfile_rename_rdport #(
      .XLEN(XLEN), .ISSUE_W(ISSUE_W)
`ifdef REGFILE_CMT_BYPASS_EN
      , .COMMIT_W(COMMIT_W)
`endif
    ) u_j (
      .src(iss_rs1[6*k+:6]), .older(iss_valid & OLDER), .iss_rd(iss_rd), .iss_tag(iss_tag),
      .busy(busy_q[a]), .tag(reorder_q[a]), .value(value_q[a]),
`ifdef REGFILE_CMT_BYPASS_EN
      .byp_en(rdy && !rollback), .cmt_valid(cmt_valid), .cmt_tag(cmt_tag), .cmt_rd(cmt_rd), .cmt_data(cmt_data),
`endif
      .q(Qj[ROB_W*k+:ROB_W]), .v(Vj[XLEN*k+:XLEN])
    );
    regfile_rename_rdport #(
      .XLEN(XLEN), .ISSUE_W(ISSUE_W)
`ifdef REGFILE_CMT_BYPASS_EN
      , .COMMIT_W(COMMIT_W)
`endif
    ) u_k (
      .src(iss_rs2[6*k+:6]), .older(iss_valid & OLDER), .iss_rd(iss_rd), .iss_tag(iss_tag),
      .busy(busy_q[b]), .tag(reorder_q[b]), .value(value_q[b]),
`ifdef REGFILE_CMT_BYPASS_EN
      .byp_en(rdy && !rollback), .cmt_valid(cmt_valid), .cmt_tag(cmt_tag), .cmt_rd(cmt_rd), .cmt_data(cmt_data),
`endif
      .q(Qk[ROB_W*k+:ROB_W]), .v(Vk[XLEN*k+:XLEN])
    );
  end
endmodule

// File: tb/tb_regfile_rename_mw.sv
// tb_regfile_rename_mw: directed scoreboard bench for regfile_rename_mw
module tb_regfile_rename_mw;
  import regfile_rename_mw_pkg::*;
  localparam int XLEN = 32;
  localparam int IW = 2;
  localparam int CW = 2;
  localparam logic [5:0] NUL = 6'h20;
  localparam logic [ROB_W-1:0] EN = ENTRY_NULL;
  logic clk = 1'b0;
  logic rst, rdy, rollback;
  logic [IW-1:0] iss_valid;
  logic [6*IW-1:0] iss_rd, iss_rs1, iss_rs2;
  logic [ROB_W*IW-1:0] iss_tag, Qj, Qk;
  logic [XLEN*IW-1:0] Vj, Vk;
  logic [CW-1:0] cmt_valid;
  logic [ROB_W*CW-1:0] cmt_tag;
  logic [6*CW-1:0] cmt_rd;
  logic [XLEN*CW-1:0] cmt_data;
  int n_cmp = 0;
  int n_fail = 0;
  typedef struct {
    string name;
    int k;
    bit s;
    logic [ROB_W-1:0] q;
    logic [XLEN-1:0] v;
  } exp_t;
  exp_t sb[$];
  regfile_rename_mw dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_tag(iss_tag),
    .Qj(Qj), .Qk(Qk), .Vj(Vj), .Vk(Vk),
    .cmt_valid(cmt_valid), .cmt_tag(cmt_tag), .cmt_rd(cmt_rd), .cmt_data(cmt_data)
  );
  always #5 clk = ~clk;
  task automatic idle();
    rollback = 1'b0;
    rdy = 1'b1;
    iss_valid = '0;
    iss_rd = {IW{NUL}};
    iss_rs1 = {IW{NUL}};
    iss_rs2 = {IW{NUL}};
    iss_tag = '0;
    cmt_valid = '0;
    cmt_tag = '0;
    cmt_rd = {CW{NUL}};
    cmt_data = '0;
  endtask
  task automatic iss(input int k, input logic [5:0] rd, input logic [ROB_W-1:0] tag);
    iss_valid[k] = 1'b1;
    iss_rd[6*k+:6] = rd;
    iss_tag[ROB_W*k+:ROB_W] = tag;
  endtask
  task automatic src(input int k, input logic [5:0] rs1, input logic [5:0] rs2);
    iss_rs1[6*k+:6] = rs1;
    iss_rs2[6*k+:6] = rs2;
  endtask
  task automatic cmt(input int c, input logic [ROB_W-1:0] tag, input logic [5:0] rd, input logic [XLEN-1:0] d);
    cmt_valid[c] = 1'b1;
    cmt_tag[ROB_W*c+:ROB_W] = tag;
    cmt_rd[6*c+:6] = rd;
    cmt_data[XLEN*c+:XLEN] = d;
  endtask
  task automatic expect_rd(input string name, input int k, input bit s, input logic [ROB_W-1:0] q, input logic [XLEN-1:0] v);
    sb.push_back('{name, k, s, q, v});
  endtask
  task automatic check();
    exp_t e;
    logic [ROB_W-1:0] oq;
    logic [XLEN-1:0] ov;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      oq = e.s ? Qk[ROB_W*e.k+:ROB_W] : Qj[ROB_W*e.k+:ROB_W];
      ov = e.s ? Vk[XLEN*e.k+:XLEN] : Vj[XLEN*e.k+:XLEN];
      n_cmp++;
      assert (oq === e.q) else begin
        n_fail++;
        $error("FAIL %s.q observed=%h expected=%h", e.name, oq, e.q);
      end
      n_cmp++;
      assert (ov === e.v) else begin
        n_fail++;
        $error("FAIL %s.v observed=%h expected=%h", e.name, ov, e.v);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask
  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    src(0, 6'd5, 6'd0);
    src(1, 6'd7, NUL);
    expect_rd("rst_x5", 0, 0, EN, 0);
    expect_rd("rst_x0", 0, 1, EN, 0);
    expect_rd("rst_x7", 1, 0, EN, 0);
    expect_rd("rst_null", 1, 1, EN, 0);
    check();
    cmt(0, 4'd0, 6'd0, 32'hDEAD);
    step();
    src(0, 6'd0, 6'd5);
    expect_rd("x0_after_write", 0, 0, EN, 0);
    expect_rd("x5_idle", 0, 1, EN, 0);
    check();
    step();
    iss(0, 6'd3, 4'd2);
    src(0, 6'd3, NUL);
    src(1, 6'd3, 6'd3);
    expect_rd("grp_lane0_self", 0, 0, EN, 0);
    expect_rd("grp_fwd_j", 1, 0, 4'd2, 0);
    expect_rd("grp_fwd_k", 1, 1, 4'd2, 0);
    check();
    step();
    src(0, 6'd3, NUL);
    expect_rd("busy_x3", 0, 0, 4'd2, 0);
    check();
    step();
    cmt(0, 4'd2, 6'd3, 32'h55);
    step();
    src(0, 6'd3, NUL);
    expect_rd("cmt_x3", 0, 0, EN, 32'h55);
    check();
    step();
    iss(0, 6'd4, 4'd1);
    step();
    iss(0, 6'd4, 4'd6);
    step();
    src(0, 6'd4, NUL);
    expect_rd("reissue_x4", 0, 0, 4'd6, 0);
    check();
    cmt(0, 4'd1, 6'd4, 32'd7);
    step();
    src(1, NUL, 6'd4);
    expect_rd("stale_cmt_x4", 1, 1, 4'd6, 0);
    check();
    cmt(0, 4'd6, 6'd4, 32'h66);
    step();
    src(0, 6'd4, NUL);
    expect_rd("final_cmt_x4", 0, 0, EN, 32'h66);
    check();
    cmt(0, 4'd9, 6'd4, 32'h11);
    cmt(1, 4'd10, 6'd4, 32'h22);
    src(0, 6'd4, NUL);
    expect_rd("dual_cmt_same", 0, 0, EN, 32'h66);
    check();
    step();
    src(0, 6'd4, NUL);
    expect_rd("dual_cmt_hi", 0, 0, EN, 32'h22);
    check();
    step();
    iss(0, 6'd8, 4'd3);
    step();
    cmt(0, 4'd3, 6'd8, 32'h88);
    iss(0, 6'd8, 4'd5);
    step();
    src(0, 6'd8, NUL);
    expect_rd("iss_over_cmt", 0, 0, 4'd5, 0);
    check();
    iss(0, 6'd9, 4'd7);
    iss(1, 6'd9, 4'd8);
    src(1, 6'd9, NUL);
    expect_rd("fwd_older_only", 1, 0, 4'd7, 0);
    check();
    step();
    src(0, 6'd9, NUL);
    expect_rd("iss_hi_lane", 0, 0, 4'd8, 0);
    check();
    step();
    iss(0, 6'd1, 4'd11);
    iss(1, 6'd2, 4'd12);
    step();
    src(0, 6'd1, 6'd2);
    expect_rd("busy_x1", 0, 0, 4'd11, 0);
    expect_rd("busy_x2", 0, 1, 4'd12, 0);
    check();
    rollback = 1'b1;
    cmt(0, 4'd4, 6'd1, 32'd9);
    iss(1, 6'd10, 4'd13);
    src(0, 6'd1, NUL);
    expect_rd("rb_no_byp", 0, 0, 4'd11, 0);
    check();
    step();
    src(0, 6'd1, 6'd2);
    src(1, 6'd8, 6'd10);
    expect_rd("rb_x1", 0, 0, EN, 32'd9);
    expect_rd("rb_x2", 0, 1, EN, 0);
    expect_rd("rb_x8", 1, 0, EN, 32'h88);
    expect_rd("rb_iss_ignored", 1, 1, EN, 0);
    check();
    step();
    iss(0, 6'd3, 4'd2);
    step();
    rdy = 1'b0;
    cmt(0, 4'd2, 6'd3, 32'hAB);
    iss(1, 6'd20, 4'd14);
    src(0, 6'd3, NUL);
    expect_rd("pause_no_byp", 0, 0, 4'd2, 0);
    check();
    step();
    src(0, 6'd3, 6'd20);
    expect_rd("pause_x3", 0, 0, 4'd2, 0);
    expect_rd("pause_x20", 0, 1, EN, 0);
    check();
    cmt(0, 4'd2, 6'd3, 32'hAB);
    src(0, 6'd3, NUL);
`ifdef REGFILE_CMT_BYPASS_EN
    expect_rd("byp_x3", 0, 0, EN, 32'hAB);
`else
    expect_rd("byp_x3", 0, 0, 4'd2, 0);
`endif
    check();
    step();
    src(0, 6'd3, NUL);
    expect_rd("post_cmt_x3", 0, 0, EN, 32'hAB);
    check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
